led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset, with ports clk_i and rst_i.
REQ-002 Parameter N_LED, default 8, SHALL set the number of LED outputs (legal range 2..16).
REQ-003 Parameter POS_W, default 3, SHALL set the pos_o width and SHALL satisfy 2**POS_W >= N_LED.
REQ-004 clk_i  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst_i  in  1  synchronous reset, active high.
REQ-006 slow_clk_i  in  1  slow square wave (e.g. 2 Hz divider output), registered in the clk_i domain.
REQ-007 en_i  in  1  1 = advance the pattern on slow_clk_i rising edges; 0 = freeze the pattern.
REQ-008 mode_i  in  2  pattern select: 00 OFF, 01 SHIFT, 10 BOUNCE, 11 BLINK.
REQ-009 dir_i  in  1  SHIFT direction: 0 = up, 1 = down; ignored in other modes.
REQ-010 bright_i  in  4  brightness 0..15; 0 = dark, 15 = always on.
REQ-011 led_o  out  N_LED  LED drive.
REQ-012 pos_o  out  POS_W  current lit position; 0 in OFF and BLINK.
REQ-013 step_o  out  1  one-cycle pulse when the pattern advanced.
REQ-014 wrap_o  out  1  one-cycle pulse, coincident with step_o, on SHIFT wrap or BOUNCE reversal.

Function
REQ-015 Edge detect: slow_q SHALL register slow_clk_i each cycle; a step event SHALL exist in a cycle where slow_clk_i=1, slow_q=0, and en_i=1.
REQ-016 A step event SHALL update the pattern state at that clock edge; the new pattern and step_o=1 SHALL appear in the following cycle (latency 1).
REQ-017 With en_i=0, edges SHALL be discarded (not deferred); pattern, pos_o, and direction SHALL hold; led_o SHALL keep displaying the held pattern.
REQ-018 Mode change: mode_q SHALL register mode_i. When mode_i != mode_q, the pattern SHALL reinitialise on that edge: pos=0, BOUNCE up flag=1, BLINK phase=1. Any simultaneous step event SHALL be discarded, with no step_o or wrap_o.
REQ-019 OFF: pattern = all zeros; step events SHALL be ignored, with no step_o.
REQ-020 SHIFT: pattern = one-hot at bit pos. dir_i=0: pos+1, with N_LED-1 wrapping to 0. dir_i=1: pos-1, with 0 wrapping to N_LED-1. wrap_o SHALL pulse on either wrap.
REQ-021 SHIFT: dir_i SHALL be sampled at the step event; a direction change SHALL NOT reinitialise pos.
REQ-022 BOUNCE: pattern = one-hot at pos.
  - Up and pos<N_LED-1: pos+1.
  - Up and pos=N_LED-1: up=0, pos=N_LED-2, wrap_o.
  - Down and pos>0: pos-1.
  - Down and pos=0: up=1, pos=1, wrap_o.
REQ-023 BLINK: phase SHALL toggle per step; pattern = all ones when phase=1, else zeros; wrap_o never.
REQ-024 PWM: pwm_cnt SHALL free-run 0..14 and wrap to 0 (period 15 cycles). pwm_on = (pwm_cnt < bright_i).
REQ-025 led_o SHALL equal pattern AND {N_LED{pwm_on}}, combinational from registered pattern, registered pwm_cnt, and bright_i.
REQ-026 bright_i=15 SHALL give pwm_on=1 in every cycle; bright_i=0 SHALL give led_o=0 in every cycle.
REQ-027 The block SHALL produce no X on any output after the first reset cycle.

Reset
REQ-028 While rst_i=1: pos=0, up=1, phase=1, pwm_cnt=0, mode_q=00, step_o=0, wrap_o=0.
REQ-029 Reset SHALL set slow_q=1, so a slow_clk_i already high at reset release produces no step.
REQ-030 Reset SHALL take priority over step events and mode changes in the same cycle; reset mid-pattern SHALL abandon the pattern.
REQ-031 On the first cycle after reset with mode_i!=00, REQ-018 SHALL apply (reinitialise, no step).

Verification
REQ-032 SHIFT, dir 0, bright 15, N_LED=8: 9 slow_clk_i rising edges -> led_o 02,04,...,80,01,02; wrap_o only on the 80->01 step; each change 1 cycle after the sampled edge.
REQ-033 BOUNCE, 16 edges -> pos_o 1..7,6..0,1,2; wrap_o at the pos 7->6 and 0->1 steps only.
REQ-034 BLINK, bright 5, 2 edges -> phase 0 then 1; led_o=FF for 5 of every 15 cycles, else 00, while phase=1.
REQ-035 SHIFT at pos 5, en_i=0 across 3 edges -> pos_o stays 5, no step_o; en_i=1 -> the next edge gives pos 6.
REQ-036 Mode change SHIFT->BOUNCE in the same cycle as an edge -> pos_o=0, no step_o or wrap_o; the next edge gives pos_o=1.
REQ-037 slow_clk_i held high through reset release -> no step until a low-then-high transition; rst_i pulsed at pos 4 -> pos_o=0, led_o=01 next cycle.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: OFF / SHIFT / BOUNCE / BLINK advanced by a slow strobe, PWM-dimmed output.
// Latency: pattern, step_o and wrap_o update one cycle after the sampled slow_clk_i rising edge.
// Backpressure: none; edges arriving with en_i=0 or during a mode change are dropped, not queued.
module led_seq_ctrl #(
  parameter int N_LED = 8,
  parameter int POS_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             slow_clk_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic [3:0]       bright_i,
  output logic [N_LED-1:0] led_o,
  output logic [POS_W-1:0] pos_o,
  output logic             step_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_PREV = POS_W'(N_LED - 2);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [3:0]       PWM_TOP  = 4'd14;

  mode_e            mode_q;
  mode_e            mode_d;
  logic             slow_q;
  logic [POS_W-1:0] pos_q,   pos_d;
  logic             up_q,    up_d;
  logic             phase_q, phase_d;
  logic             step_q,  step_d;
  logic             wrap_q,  wrap_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;

  logic             step_ev;
  logic             mode_chg;
  logic             pwm_on;
  logic [N_LED-1:0] pattern;

  assign mode_d   = mode_e'(mode_i);
  assign step_ev  = slow_clk_i & ~slow_q & en_i;
  assign mode_chg = (mode_d != mode_q);

  // Next pattern state: a mode change reinitialises and swallows any coincident step.
  always_comb begin
    pos_d   = pos_q;
    up_d    = up_q;
    phase_d = phase_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode_chg) begin
      pos_d   = '0;
      up_d    = 1'b1;
      phase_d = 1'b1;
    end else if (step_ev) begin
      unique case (mode_q)
        MODE_OFF: begin
        end
        MODE_SHIFT: begin
          step_d = 1'b1;
          if (!dir_i) begin
            if (pos_q == POS_LAST) begin
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d  = POS_LAST;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        MODE_BOUNCE: begin
          step_d = 1'b1;
          if (up_q) begin
            if (pos_q == POS_LAST) begin
              up_d   = 1'b0;
              pos_d  = POS_PREV;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              up_d   = 1'b1;
              pos_d  = POS_ONE;
              wrap_d = 1'b1;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        MODE_BLINK: begin
          step_d  = 1'b1;
          phase_d = ~phase_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Free-running PWM counter, period 15 so bright_i=15 means always on.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? 4'd0 : pwm_cnt_q + 4'd1;
  end

  // State registers; slow_q resets high so a strobe already high at release is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= MODE_OFF;
      slow_q    <= 1'b1;
      pos_q     <= '0;
      up_q      <= 1'b1;
      phase_q   <= 1'b1;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      pwm_cnt_q <= 4'd0;
    end else begin
      mode_q    <= mode_d;
      slow_q    <= slow_clk_i;
      pos_q     <= pos_d;
      up_q      <= up_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      wrap_q    <= wrap_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Displayed pattern from registered state, gated by the PWM duty.
  always_comb begin
    pattern = '0;
    pos_o   = '0;
    unique case (mode_q)
      MODE_OFF: begin
      end
      MODE_SHIFT, MODE_BOUNCE: begin
        pattern = N_LED'(1) << pos_q;
        pos_o   = pos_q;
      end
      MODE_BLINK: begin
        pattern = phase_q ? '1 : '0;
      end
      default: begin
      end
    endcase
    pwm_on = (pwm_cnt_q < bright_i);
    led_o  = pattern & {N_LED{pwm_on}};
  end

  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomised plus directed bench for led_seq_ctrl with a queue-based scoreboard.
// The driver pushes the expected outputs of each clock edge; the monitor pops after the edge.
// Reference model: SHIFT as modular position, BOUNCE as an index into its 2N-2 long round trip.
module tb_led_seq_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       slow_clk_i;
  logic       en_i;
  logic [1:0] mode_i;
  logic       dir_i;
  logic [3:0] bright_i;
  logic [7:0] led_o;
  logic [2:0] pos_o;
  logic       step_o;
  logic       wrap_o;

  led_seq_ctrl #(.N_LED(N), .POS_W(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .slow_clk_i (slow_clk_i),
    .en_i       (en_i),
    .mode_i     (mode_i),
    .dir_i      (dir_i),
    .bright_i   (bright_i),
    .led_o      (led_o),
    .pos_o      (pos_o),
    .step_o     (step_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic [2:0] pos;
    logic       step;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Stimulus variables applied once per cycle
  logic       r_rst = 1'b1;
  logic       r_slow = 1'b0;
  logic       r_en = 1'b1;
  logic [1:0] r_mode = 2'b00;
  logic       r_dir = 1'b0;
  logic [3:0] r_bright = 4'd15;

  // Reference model state
  int   m_mode  = 0;
  int   m_prev  = 1;
  int   m_pos   = 0;   // SHIFT position
  int   m_k     = 0;   // BOUNCE round-trip index, 0..2N-2
  int   m_phase = 1;
  int   m_pwm   = 0;   // cycles since reset, mod 15

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  // Apply inputs for the coming edge, predict outputs after it, then wait for negedge.
  task automatic cyc();
    exp_t e;
    int   ev;
    int   st;
    int   wr;
    int   bp;
    logic [7:0] pat;
    rst_i      = r_rst;
    slow_clk_i = r_slow;
    en_i       = r_en;
    mode_i     = r_mode;
    dir_i      = r_dir;
    bright_i   = r_bright;
    st = 0;
    wr = 0;
    if (r_rst) begin
      m_mode = 0; m_prev = 1; m_pos = 0; m_k = 0; m_phase = 1; m_pwm = 0;
    end else begin
      ev     = (r_slow && !m_prev && r_en) ? 1 : 0;
      m_prev = int'(r_slow);
      m_pwm  = (m_pwm + 1) % 15;
      if (int'(r_mode) != m_mode) begin
        m_mode = int'(r_mode); m_pos = 0; m_k = 0; m_phase = 1;
      end else if (ev != 0 && m_mode != 0) begin
        st = 1;
        case (m_mode)
          1: begin
            if (!r_dir) begin
              wr = (m_pos == N - 1) ? 1 : 0;
              m_pos = (m_pos + 1) % N;
            end else begin
              wr = (m_pos == 0) ? 1 : 0;
              m_pos = (m_pos + N - 1) % N;
            end
          end
          2: begin
            if (m_k == 2 * N - 2) begin
              m_k = 1; wr = 1;
            end else begin
              m_k = m_k + 1;
              wr = (m_k == N) ? 1 : 0;
            end
          end
          default: m_phase = 1 - m_phase;
        endcase
      end
    end
    bp = (m_k <= N - 1) ? m_k : 2 * N - 2 - m_k;
    case (m_mode)
      1: begin pat = 8'h01 << m_pos; e.pos = 3'(m_pos); end
      2: begin pat = 8'h01 << bp;    e.pos = 3'(bp); end
      3: begin pat = (m_phase != 0) ? 8'hFF : 8'h00; e.pos = 3'd0; end
      default: begin pat = 8'h00; e.pos = 3'd0; end
    endcase
    e.led  = (m_pwm < int'(r_bright)) ? pat : 8'h00;
    e.step = (st != 0);
    e.wrap = (wr != 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // One low-then-high strobe transition
  task automatic slow_edge();
    r_slow = 1'b0; cycles(2);
    r_slow = 1'b1; cycles(2);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) slow_edge();
  endtask

  // Monitor: after each edge compare DUT outputs against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("queue_underflow", 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        check("led_o",  led_o,          e.led);
        check("pos_o",  {5'd0, pos_o},  {5'd0, e.pos});
        check("step_o", {7'd0, step_o}, {7'd0, e.step});
        check("wrap_o", {7'd0, wrap_o}, {7'd0, e.wrap});
      end
    end
  end

  initial begin
    // Reset with the strobe already high, release it still high
    r_rst = 1'b1; r_slow = 1'b1; cycles(3);
    r_rst = 1'b0; r_mode = 2'b01; cycles(4);
    // SHIFT up through a wrap
    edges(9);
    // BOUNCE full round trip plus two
    r_mode = 2'b10; cycles(2);
    edges(16);
    // BLINK dimmed
    r_bright = 4'd5; r_mode = 2'b11; cycles(2);
    edges(2);
    cycles(30);
    // SHIFT to pos 5, then freeze for three edges
    r_bright = 4'd15; r_mode = 2'b01; cycles(2);
    edges(5);
    r_en = 1'b0; edges(3);
    r_en = 1'b1; edges(1);
    // Mode change coincident with an edge
    r_slow = 1'b0; cyc();
    r_slow = 1'b1; r_mode = 2'b10; cycles(2);
    edges(1);
    // SHIFT to pos 4, then reset mid-pattern
    r_mode = 2'b01; cycles(2);
    edges(4);
    r_rst = 1'b1; cyc();
    r_rst = 1'b0; cycles(3);
    // SHIFT down through a wrap
    r_dir = 1'b1; edges(3);
    // OFF ignores edges; zero brightness
    r_mode = 2'b00; cycles(2); edges(2);
    r_mode = 2'b01; r_bright = 4'd0; cycles(2); edges(2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) r_slow = ~r_slow;
      if ($urandom_range(0, 59) == 0) r_mode = 2'($urandom_range(0, 3));
      r_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
      if ($urandom_range(0, 39) == 0) r_bright = 4'($urandom_range(0, 15));
      cyc();
    end
    r_rst = 1'b0;
    // Let the monitor drain the last expectation, bounded by a cycle budget
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
